xor_sched: RTL and testbench

Round-robin scheduler that shares one registered XOR unit between `REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one request at a time, sequences it through the XOR unit and returns the result with the winner's ID on a single response channel. It sits between the task-level producers and the XOR datapath, so the datapath needs only one instance.

---
 rtl/xor_sched_pkg.sv | 27 ++
 rtl/xor_core.sv | 33 +++
 rtl/xor_sched.sv | 143 ++++++++++++++
 tb/tb_xor_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_sched_pkg.sv
//------------------------------------------------------------------------------
// xor_sched_pkg
// Shared state encoding and ID-width helper for the XOR scheduler.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package xor_sched_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_CALC = c_ST_CALC,
        ST_RESP = c_ST_RESP
    } xor_sched_state_t;

    // A single requester index still needs one bit to be representable.
    function automatic int id_width(input int req);
        return (req > 2) ? $clog2(req) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xor_core.sv
//------------------------------------------------------------------------------
// xor_core
// Registered N-bit XOR unit, one cycle of latency, loads on load_i.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xor_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o
);

    logic [N-1:0] y_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_q <= '0;
        end else if (load_i) begin
            y_q <= a_i ^ b_i;
        end
    end

    assign y_o = y_q;

endmodule

`default_nettype wire

// File: rtl/xor_sched.sv
//------------------------------------------------------------------------------
// xor_sched
// Arbitrates REQ requesters onto one shared registered XOR unit and returns
// each result with the winner's ID. Define XOR_SCHED_FIXPRI_EN for
// fixed-priority arbitration (lowest index wins) instead of round-robin.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xor_sched
    import xor_sched_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int REQ  = 4,
    localparam int ID_W = id_width(REQ)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REQ-1:0]    req_valid,
    output logic [REQ-1:0]    req_ready,
    input  logic [REQ*N-1:0]  req_a,
    input  logic [REQ*N-1:0]  req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [ID_W-1:0]   rsp_id
);

    xor_sched_state_t state_q, state_d;

    logic [REQ-1:0]  grant;
    logic [ID_W-1:0] win;
    logic            accept;

    logic [N-1:0]    op_a_q, op_b_q;
    logic [ID_W-1:0] id_q;

`ifdef XOR_SCHED_FIXPRI_EN
    // Scan downward so the lowest valid index is the last one written.
    always_comb begin
        grant = '0;
        win   = '0;
        for (int i = REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                win      = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_q;
    logic            found;
    int              idx;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= REQ) begin
                idx = idx - REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (win == ID_W'(REQ - 1)) ? '0 : win + ID_W'(1);
        end
    end
`endif

    assign accept = (state_q == ST_IDLE) && (|req_valid);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gate with rstn so no handshake is advertised during reset.
                req_ready = rstn ? grant : '0;
                if (|req_valid) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q <= req_a[int'(win)*N +: N];
                op_b_q <= req_b[int'(win)*N +: N];
                id_q   <= win;
            end
        end
    end

    xor_core #(
        .N (N)
    ) u_xor_core (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (state_q == ST_CALC),
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .y_o    (rsp_data)
    );

    assign rsp_id = id_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_sched.sv
//------------------------------------------------------------------------------
// tb_xor_sched
// Directed self-checking bench for xor_sched at N=4, REQ=4.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_xor_sched;

    logic        clk;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;

    int checks;
    int failures;

    xor_sched #(
        .N   (4),
        .REQ (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    task automatic apply_reset();
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready: got=%b expected=%b", req_ready, 4'b0000);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== 7'd0) begin
            failures++;
            $display("FAIL reset_rsp: got valid=%b id=%0d data=%h expected all 0",
                     rsp_valid, rsp_id, rsp_data);
        end
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        set_op(0, 4'hA, 4'h5);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: req_ready=%b expected=%b", req_ready, 4'b0001);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL single_calc: valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 4'hF}) begin
            failures++;
            $display("FAIL single_rsp: valid=%b id=%0d data=%h expected 1/0/f",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
            failures++;
            $display("FAIL single_idle_again: valid=%b ready=%b expected 0/0010",
                     rsp_valid, req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_data [4];
        logic [3:0] exp_grant;
        int         e;
        exp_data = '{4'h3, 4'h5, 4'h9, 4'hC};
        apply_reset();
        set_op(0, 4'h1, 4'h2);
        set_op(1, 4'h6, 4'h3);
        set_op(2, 4'hC, 4'h5);
        set_op(3, 4'h3, 4'hF);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            e         = k % 4;
            exp_grant = 4'(1) << e;
            #1;
            checks++;
            if (req_ready !== exp_grant) begin
                failures++;
                $display("FAIL rr_grant[%0d]: req_ready=%b expected=%b", k, req_ready, exp_grant);
            end
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rr_calc[%0d]: rsp_valid=%b expected=0", k, rsp_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(e), exp_data[e]}) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: valid=%b id=%0d data=%h expected 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_data, e, exp_data[e]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_op(1, 4'h9, 4'h3);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant: req_ready=%b expected=0010", req_ready);
        end
        @(negedge clk);
        set_op(3, 4'h7, 4'h1);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_calc_ready: req_ready=%b expected=0000", req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) rsp_ready = 1'b1;
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd1, 4'hA, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d data=%h ready=%b expected 1/1/a/0000",
                         i, rsp_valid, rsp_id, rsp_data, req_ready);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin
            failures++;
            $display("FAIL bp_next_grant: valid=%b ready=%b expected 0/1000", rsp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd3, 4'h6}) begin
            failures++;
            $display("FAIL bp_second_rsp: valid=%b id=%0d data=%h expected 1/3/6",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_calc();
        apply_reset();
        set_op(2, 4'h5, 4'hC);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL rst_calc_grant: req_ready=%b expected=0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rstn      = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL rst_calc_during: valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_calc_no_rsp[%0d]: rsp_valid=%b expected=0", i, rsp_valid);
            end
        end
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL rst_calc_ptr_a: req_ready=%b expected=0010", req_ready);
        end
        req_valid = 4'b1110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL rst_calc_ptr_b: req_ready=%b expected=0010", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_drop_in_calc();
        int seen3;
        apply_reset();
        set_op(0, 4'h8, 4'h1);
        set_op(3, 4'hF, 4'h0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL drop_grant: req_ready=%b expected=0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL drop_calc_ready: req_ready=%b expected=0000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 4'h9}) begin
            failures++;
            $display("FAIL drop_rsp: valid=%b id=%0d data=%h expected 1/0/9",
                     rsp_valid, rsp_id, rsp_data);
        end
        seen3 = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_id == 2'd3) seen3++;
        end
        checks++;
        if (seen3 !== 0) begin
            failures++;
            $display("FAIL drop_never_served: id3 responses=%0d expected=0", seen3);
        end
    endtask

    task automatic test_pair_arbitration();
        int         order [4];
        logic [3:0] exp_grant;
        logic [3:0] exp_data;
`ifdef XOR_SCHED_FIXPRI_EN
        order = '{1, 1, 1, 1};
`else
        order = '{1, 3, 1, 3};
`endif
        apply_reset();
        set_op(1, 4'h2, 4'h4);
        set_op(3, 4'hB, 4'h1);
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_grant = 4'(1) << order[k];
            exp_data  = (order[k] == 1) ? 4'h6 : 4'hA;
            #1;
            checks++;
            if (req_ready !== exp_grant) begin
                failures++;
                $display("FAIL pair_grant[%0d]: req_ready=%b expected=%b", k, req_ready, exp_grant);
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(order[k]), exp_data}) begin
                failures++;
                $display("FAIL pair_rsp[%0d]: valid=%b id=%0d data=%h expected 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_data, order[k], exp_data);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_in_calc();
        test_drop_in_calc();
        test_pair_arbitration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
